// File: rtl/mini_alu_pkg.sv
// Shared definitions for the mini ALU: opcode encoding, default data width
// and the signed-overflow helpers used by the datapath.
package mini_alu_pkg;

  localparam int MINI_ALU_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_NOT = 3'b111
  } op_e;

  // Addition overflows when both operands share a sign the result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Subtraction overflows when operand signs differ and the result leaves A's sign.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/mini_alu_core.sv
// Purely combinational ALU datapath: result plus carry/zero/negative/overflow.
module mini_alu_core
  import mini_alu_pkg::*;
#(
  parameter int WIDTH = MINI_ALU_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;

  // Extended-width add/sub so bit WIDTH carries the carry / borrow.
  assign sum_s  = {1'b0, A} + {1'b0, B};
  assign diff_s = {1'b0, A} - {1'b0, B};

  // Operation decode; logic ops leave carry and overflow at 0.
  always_comb begin
    res      = {WIDTH{1'b0}};
    carry    = 1'b0;
    overflow = 1'b0;
    case (sel)
      OP_ADD: begin
        res      = sum_s[WIDTH-1:0];
        carry    = sum_s[WIDTH];
        overflow = add_ovf(A[WIDTH-1], B[WIDTH-1], sum_s[WIDTH-1]);
      end
      OP_SUB: begin
        res      = diff_s[WIDTH-1:0];
        carry    = ~diff_s[WIDTH];  // no borrow means A >= B unsigned
        overflow = sub_ovf(A[WIDTH-1], B[WIDTH-1], diff_s[WIDTH-1]);
      end
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_XOR: res = A ^ B;
      OP_SHL: begin
        res   = {A[WIDTH-2:0], 1'b0};
        carry = A[WIDTH-1];
      end
      OP_SHR: begin
        res   = {1'b0, A[WIDTH-1:1]};
        carry = A[0];
      end
      OP_NOT: res = ~A;
      default: begin
        res      = {WIDTH{1'b0}};
        carry    = 1'b0;
        overflow = 1'b0;
      end
    endcase
  end

  assign zero     = (res == {WIDTH{1'b0}});
  assign negative = res[WIDTH-1];

endmodule

// File: rtl/mini_alu.sv
// Mini ALU top: registers the core result and flags with one cycle of latency.
// Results and flags hold when no operation is presented; out_valid marks fresh data.
module mini_alu
  import mini_alu_pkg::*;
#(
  parameter int WIDTH = MINI_ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic             zero_s;
  logic             negative_s;
  logic             overflow_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] y_r;
  logic             carry_r;
  logic             zero_r;
  logic             negative_r;
  logic             overflow_r;

  mini_alu_core #(.WIDTH(WIDTH)) u_core (
    .A        (A),
    .B        (B),
    .sel      (sel),
    .res      (res_s),
    .carry    (carry_s),
    .zero     (zero_s),
    .negative (negative_s),
    .overflow (overflow_s)
  );

  // Output registers: reset wins, a valid op loads, otherwise hold and drop out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      y_r         <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
      negative_r  <= 1'b0;
      overflow_r  <= 1'b0;
    end else if (in_valid) begin
      out_valid_r <= 1'b1;
      y_r         <= res_s;
      carry_r     <= carry_s;
      zero_r      <= zero_s;
      negative_r  <= negative_s;
      overflow_r  <= overflow_s;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign y         = y_r;
  assign carry     = carry_r;
  assign zero      = zero_r;
  assign negative  = negative_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_mini_alu.sv
// Directed self-checking bench for mini_alu (WIDTH = 8).
// Observed word layout: {out_valid, y[7:0], carry, zero, negative, overflow}.
module tb_mini_alu;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] sel;
  logic       out_valid;
  logic [7:0] y;
  logic       carry;
  logic       zero;
  logic       negative;
  logic       overflow;

  int total;
  int bad;

  logic [12:0] got;
  logic [12:0] exp;

  mini_alu #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .sel       (sel),
    .out_valid (out_valid),
    .y         (y),
    .carry     (carry),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign got = {out_valid, y, carry, zero, negative, overflow};

  // Present one set of inputs on the falling edge, then step to just past the next rising edge.
  task automatic drive_step(input logic r, input logic v, input logic [7:0] a,
                            input logic [7:0] b, input logic [2:0] s);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    A        = a;
    B        = b;
    sel      = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_step(1'b1, 1'b1, 8'hFF, 8'h01, 3'b000);
    drive_step(1'b1, 1'b0, 8'h00, 8'h00, 3'b000);
    exp = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_sweep();
    logic [12:0] tbl [8];
    tbl[0] = {1'b1, 8'h9D, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = {1'b1, 8'h53, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = {1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = {1'b1, 8'hFD, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = {1'b1, 8'h5D, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = {1'b1, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = {1'b1, 8'h7C, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = {1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive_step(1'b0, 1'b1, 8'hF8, 8'hA5, i[2:0]);
      exp = tbl[i];
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL sweep_sel%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_add_overflow();
    drive_step(1'b0, 1'b1, 8'h7F, 8'h01, 3'b000);
    exp = {1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL add_overflow got=%h exp=%h", got, exp);
    end
    drive_step(1'b0, 1'b1, 8'h80, 8'h80, 3'b000);
    exp = {1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL add_neg_overflow got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_sub_edges();
    drive_step(1'b0, 1'b1, 8'h3C, 8'h3C, 3'b001);
    exp = {1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL sub_equal got=%h exp=%h", got, exp);
    end
    drive_step(1'b0, 1'b1, 8'h00, 8'h01, 3'b001);
    exp = {1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL sub_borrow got=%h exp=%h", got, exp);
    end
    drive_step(1'b0, 1'b1, 8'h80, 8'h01, 3'b001);
    exp = {1'b1, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL sub_overflow got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_hold();
    drive_step(1'b0, 1'b1, 8'h3C, 8'hC3, 3'b100);
    exp = {1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL hold_load got=%h exp=%h", got, exp);
    end
    for (int i = 0; i < 3; i++) begin
      drive_step(1'b0, 1'b0, 8'h11 + 8'(i), 8'h22, 3'(i));
      exp = {1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL hold_cycle%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_input_glitch();
    // Inputs wiggle between edges; only the value present at the edge counts.
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; A = 8'h01; B = 8'h02; sel = 3'b000;
    #2 A = 8'hAA;
    #2 A = 8'h10; sel = 3'b011;
    @(posedge clk);
    #1;
    A = 8'hFF; sel = 3'b111;
    #2;
    exp = {1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL input_sampling got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_reset_mid_stream();
    drive_step(1'b0, 1'b1, 8'h10, 8'h20, 3'b000);
    exp = {1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL b2b_before_reset got=%h exp=%h", got, exp);
    end
    drive_step(1'b1, 1'b1, 8'hFF, 8'hFF, 3'b000);
    exp = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL reset_discards_op got=%h exp=%h", got, exp);
    end
    drive_step(1'b0, 1'b1, 8'h81, 8'h00, 3'b110);
    exp = {1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL first_after_reset got=%h exp=%h", got, exp);
    end
    drive_step(1'b0, 1'b1, 8'h80, 8'h00, 3'b101);
    exp = {1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL shl_to_zero got=%h exp=%h", got, exp);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    A        = 8'h00;
    B        = 8'h00;
    sel      = 3'b000;
    test_reset();
    test_sweep();
    test_add_overflow();
    test_sub_edges();
    test_hold();
    test_input_glitch();
    test_reset_mid_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mini_alu.md
MINI_ALU -- requirements
Module: mini_alu

Interface
REQ-001 Parameter: WIDTH, default 8, data width of A, B and y; the bench uses 8 and all examples assume 8.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  qualifies A, B and sel in the current cycle.
REQ-006 A  input  WIDTH  first operand.
REQ-007 B  input  WIDTH  second operand.
REQ-008 sel  input  3  operation select.
REQ-009 out_valid  output  1  y and flags hold a fresh result.
REQ-010 y  output  WIDTH  registered result.
REQ-011 carry  output  1  carry, no-borrow or shifted-out bit.
REQ-012 zero  output  1  high when y == 0.
REQ-013 negative  output  1  equals y[WIDTH-1].
REQ-014 overflow  output  1  signed two's-complement overflow.

Function
REQ-015 sel decode:
- 000 ADD: y = A+B.
- 001 SUB: y = A-B.
- 010 AND: y = A&B.
- 011 OR: y = A|B.
- 100 XOR: y = A^B.
- 101 SHL: y = A<<1, LSB filled with 0.
- 110 SHR: y = A>>1, logical, MSB filled with 0.
- 111 NOT: y = ~A.
REQ-016 Results are truncated to WIDTH bits; wrap-around is modulo 2^WIDTH.
REQ-017 carry:
- ADD: bit WIDTH of the unsigned sum.
- SUB: 1 when A >= B unsigned (no borrow).
- SHL: A[WIDTH-1].
- SHR: A[0].
- All logic ops: 0.
REQ-018 overflow:
- ADD: operands have equal signs and result sign differs.
- SUB: operand signs differ and result sign differs from A.
- All other ops: 0.
REQ-019 zero and negative are computed from the new y for every op.
REQ-020 Latency is exactly 1 cycle: inputs sampled at edge N with in_valid=1 appear on y and the flags after edge N, with out_valid=1.
REQ-021 When in_valid=0 at an edge:
- y and the flags hold their previous values.
- out_valid is cleared to 0.
REQ-022 Back-to-back in_valid=1 cycles give one result per cycle with no bubbles.
REQ-023 Inputs are fully sampled at the edge; any sel/A/B change between edges has no effect on the outputs.

Reset
REQ-024 While rst=1 at a rising edge, y, carry, zero, negative, overflow and out_valid are all cleared to 0.
REQ-025 rst has priority over in_valid: an operation presented in the reset cycle is discarded.
REQ-026 The first valid operation after rst deasserts produces its result one cycle later, per REQ-020.

Structure
REQ-027 Shared package mini_alu_pkg holds:
- the 3-bit opcode enumeration (OP_ADD..OP_NOT) with the codes of REQ-015;
- the default WIDTH constant.
REQ-028 One combinational sub-module, mini_alu_core, computes the result and the four flags from A, B and sel.
REQ-029 mini_alu holds only the output registers, the valid pipeline and the reset logic.

Verification
REQ-030 A=F8, B=A5, sweep sel 000..111 with in_valid=1; each result appears one cycle later:
- 000 -> y=9D, carry=1, ovf=0
- 001 -> y=53, carry=1
- 010 -> y=A0
- 011 -> y=FD
- 100 -> y=5D
- 101 -> y=F0, carry=1
- 110 -> y=7C, carry=0
- 111 -> y=07
REQ-031 ADD with A=7F, B=01 -> y=80, overflow=1, negative=1, carry=0.
REQ-032 SUB with A=3C, B=3C -> y=00, zero=1, carry=1; SUB with A=00, B=01 -> y=FF, carry=0.
REQ-033 Valid result present, then in_valid=0 for 3 cycles -> y and flags unchanged, out_valid=0.
REQ-034 Assert rst during back-to-back operations -> all outputs 0 on the next edge; first op after release appears one cycle later.
